// File: rtl/asyn_fifo_wr_arb.sv
// Round-robin arbiter sharing one asynchronous-FIFO write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST accepted words, and the full flag gates every write.
module asyn_fifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int OWN_W     = $clog2(NUM_REQ),
  parameter int BCNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                     wr_clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic [OWN_W-1:0]         owner,
  output logic [BCNT_W-1:0]        burst_cnt,
  output logic                     busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic [OWN_W-1:0]  OWNER_RST = OWN_W'(NUM_REQ - 1);
  localparam logic [BCNT_W-1:0] CNT_LAST  = BCNT_W'(MAX_BURST - 1);

  state_e              state_q, state_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [BCNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;

  logic [OWN_W-1:0]    pick;
  logic                pick_vld;
  logic                owner_req;
  logic                accept;

  // Scan from the slot after the last owner, wrapping, so owner acts as the round-robin pointer.
  always_comb begin
    int idx;
    pick     = owner_q;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(owner_q) + i) % NUM_REQ;
      if (!pick_vld && req[idx]) begin
        pick     = OWN_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_req = req[owner_q];
  assign accept    = (state_q == ST_BURST) && owner_req && !fifo_full;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    fifo_wr_en = 1'b0;
    fifo_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          cnt_d   = '0;
          gnt_d   = NUM_REQ'(1) << pick;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        fifo_wr_en = accept;
        if (accept) begin
          fifo_wdata = req_data[owner_q*WIDTH +: WIDTH];
        end
        // A dropped request ends the burst even while the FIFO is full.
        if (!owner_req || (accept && (cnt_q == CNT_LAST))) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + BCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign burst_cnt = cnt_q;
  assign busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_asyn_fifo_wr_arb.sv
// Bench for asyn_fifo_wr_arb: directed scenarios against fixed expectations and a long
// random run against a behavioural model, with a data scoreboard and fairness tracking.
module tb_asyn_fifo_wr_arb;
  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int OWN_W     = 2;
  localparam int BCNT_W    = 3;

  // clock / reset
  logic wr_clk = 1'b0;
  logic rst_n  = 1'b1;
  always #5 wr_clk = ~wr_clk;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wdata;
  logic [OWN_W-1:0]         owner;
  logic [BCNT_W-1:0]        burst_cnt;
  logic                     busy;

  asyn_fifo_wr_arb #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .OWN_W(OWN_W), .BCNT_W(BCNT_W)
  ) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
    .owner(owner), .burst_cnt(burst_cnt), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // producer state: words left to send, words sent, data base value
  int         rem  [NUM_REQ];
  int         sent [NUM_REQ];
  logic [7:0] base [NUM_REQ];

  logic [WIDTH-1:0] exp_q[$];

  // behavioural reference: is a grant active, whose, and how many words taken so far
  bit m_active;
  int m_owner;
  int m_cnt;

  function automatic int rr_pick(int last, logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return last;
  endfunction

  always @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_owner  <= NUM_REQ - 1;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (req != '0) begin
        m_owner  <= rr_pick(m_owner, req);
        m_active <= 1'b1;
        m_cnt    <= 0;
      end
    end else if (!req[m_owner]) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (!fifo_full) begin
      if (m_cnt + 1 == MAX_BURST) begin
        m_active <= 1'b0;
        m_cnt    <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  logic [NUM_REQ-1:0] exp_gnt;
  logic               exp_wr;
  logic [WIDTH-1:0]   exp_data;
  always_comb begin
    exp_gnt  = m_active ? NUM_REQ'(1 << m_owner) : '0;
    exp_wr   = m_active && req[m_owner] && !fifo_full;
    exp_data = exp_wr ? req_data[m_owner*WIDTH +: WIDTH] : '0;
  end

  // driver tasks
  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = (rem[i] > 0);
      req_data[i*WIDTH +: WIDTH] = base[i] + 8'(sent[i]);
    end
  endtask

  // Called at a negedge: note the handshake, cross the posedge, then present next words.
  task automatic advance();
    logic               acc;
    logic [NUM_REQ-1:0] ag;
    acc = fifo_wr_en;
    ag  = gnt;
    @(posedge wr_clk);
    #1;
    if (acc)
      for (int i = 0; i < NUM_REQ; i++)
        if (ag[i]) begin
          sent[i]++;
          rem[i]--;
        end
    apply_inputs();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
      base[i] = 8'h00;
    end
    apply_inputs();
    exp_q.delete();
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
      base[i] = 8'h00;
    end
    apply_inputs();
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
    n_vec++; if (fifo_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata got=%h exp=00", fifo_wdata); end
    n_vec++; if (burst_cnt !== 3'd0) begin n_err++; $display("FAIL reset_burst_cnt got=%0d exp=0", burst_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (owner !== 2'd3) begin n_err++; $display("FAIL reset_owner got=%0d exp=3", owner); end
  endtask

  task automatic test_single_req();
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset();
    base[0] = 8'hA0;
    rem[0]  = 1000;
    apply_inputs();
    for (int c = 0; c <= 6; c++) begin
      @(negedge wr_clk);
      eg = ((c >= 1 && c <= 4) || c == 6) ? 4'b0001 : 4'b0000;
      ed = (eg == 4'b0000) ? 8'h00 : (c <= 4 ? 8'(8'hA0 + c - 1) : 8'hA4);
      n_vec++; if (gnt !== eg) begin n_err++; $display("FAIL single_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      n_vec++; if (fifo_wr_en !== eg[0]) begin n_err++; $display("FAIL single_wr_en cyc=%0d got=%b exp=%b", c, fifo_wr_en, eg[0]); end
      n_vec++; if (fifo_wdata !== ed) begin n_err++; $display("FAIL single_wdata cyc=%0d got=%h exp=%h", c, fifo_wdata, ed); end
      n_vec++; if (busy !== (eg != 4'b0000)) begin n_err++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, eg != 4'b0000); end
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [7:0] ed;
    int k, pos, own;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      base[i] = 8'(i*16 + 8);
      rem[i]  = 1000;
    end
    apply_inputs();
    for (int c = 0; c <= 25; c++) begin
      @(negedge wr_clk);
      eg = 4'b0000; ed = 8'h00; own = -1;
      if (c > 0) begin
        k   = (c - 1) / 5;
        pos = (c - 1) % 5;
        if (pos < 4) begin
          own = k % NUM_REQ;
          eg  = 4'(1 << own);
          ed  = 8'(own*16 + 8 + (k / NUM_REQ)*4 + pos);
        end
      end
      n_vec++; if (gnt !== eg) begin n_err++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      n_vec++; if (fifo_wdata !== ed) begin n_err++; $display("FAIL rr_wdata cyc=%0d got=%h exp=%h", c, fifo_wdata, ed); end
      if (own >= 0) begin
        n_vec++; if (owner !== 2'(own)) begin n_err++; $display("FAIL rr_owner cyc=%0d got=%0d exp=%0d", c, owner, own); end
      end
      advance();
    end
  endtask

  task automatic test_full_stall();
    logic [3:0] eg;
    logic       ew;
    logic [2:0] ec;
    logic [7:0] e;
    do_reset();
    base[1] = 8'h30;
    rem[1]  = 4;
    for (int w = 0; w < 4; w++) exp_q.push_back(8'(8'h30 + w));
    apply_inputs();
    for (int c = 0; c <= 9; c++) begin
      fifo_full = (c >= 2 && c <= 4);
      @(negedge wr_clk);
      eg = (c >= 1 && c <= 7) ? 4'b0010 : 4'b0000;
      ew = (c == 1) || (c >= 5 && c <= 7);
      ec = (c >= 2 && c <= 5) ? 3'd1 : (c == 6) ? 3'd2 : (c == 7) ? 3'd3 : 3'd0;
      n_vec++; if (gnt !== eg) begin n_err++; $display("FAIL stall_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      n_vec++; if (fifo_wr_en !== ew) begin n_err++; $display("FAIL stall_wr_en cyc=%0d got=%b exp=%b", c, fifo_wr_en, ew); end
      n_vec++; if (burst_cnt !== ec) begin n_err++; $display("FAIL stall_burst_cnt cyc=%0d got=%0d exp=%0d", c, burst_cnt, ec); end
      if (fifo_wr_en === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_extra_write cyc=%0d got=%h exp=none", c, fifo_wdata); end
        else begin
          e = exp_q.pop_front();
          if (fifo_wdata !== e) begin n_err++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, fifo_wdata, e); end
        end
      end
      advance();
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_missing_writes got=%0d_left exp=0_left", exp_q.size()); end
  endtask

  task automatic test_req_drop();
    logic [3:0] eg;
    logic       ew;
    logic [7:0] e;
    do_reset();
    base[0] = 8'h40; rem[0] = 2;
    base[2] = 8'h60; rem[2] = 4;
    exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    for (int w = 0; w < 4; w++) exp_q.push_back(8'(8'h60 + w));
    apply_inputs();
    for (int c = 0; c <= 9; c++) begin
      @(negedge wr_clk);
      eg = (c >= 1 && c <= 3) ? 4'b0001 : (c >= 5 && c <= 8) ? 4'b0100 : 4'b0000;
      ew = (c == 1) || (c == 2) || (c >= 5 && c <= 8);
      n_vec++; if (gnt !== eg) begin n_err++; $display("FAIL drop_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      n_vec++; if (fifo_wr_en !== ew) begin n_err++; $display("FAIL drop_wr_en cyc=%0d got=%b exp=%b", c, fifo_wr_en, ew); end
      if (c == 3) begin
        n_vec++; if (burst_cnt !== 3'd2) begin n_err++; $display("FAIL drop_burst_cnt got=%0d exp=2", burst_cnt); end
      end
      if (fifo_wr_en === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL drop_extra_write cyc=%0d got=%h exp=none", c, fifo_wdata); end
        else begin
          e = exp_q.pop_front();
          if (fifo_wdata !== e) begin n_err++; $display("FAIL drop_data cyc=%0d got=%h exp=%h", c, fifo_wdata, e); end
        end
      end
      advance();
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drop_missing_writes got=%0d_left exp=0_left", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      base[i] = 8'(8'h80 + i*16);
      rem[i]  = 1000;
    end
    apply_inputs();
    repeat (3) begin
      @(negedge wr_clk);
      advance();
    end
    @(negedge wr_clk);
    n_vec++; if (burst_cnt !== 3'd2) begin n_err++; $display("FAIL areset_pre_cnt got=%0d exp=2", burst_cnt); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL areset_gnt got=%b exp=0000", gnt); end
    n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL areset_wr_en got=%b exp=0", fifo_wr_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b exp=0", busy); end
    n_vec++; if (burst_cnt !== 3'd0) begin n_err++; $display("FAIL areset_cnt got=%0d exp=0", burst_cnt); end
    n_vec++; if (owner !== 2'd3) begin n_err++; $display("FAIL areset_owner got=%0d exp=3", owner); end
    @(posedge wr_clk);
    @(negedge wr_clk);
    rst_n = 1'b1;
    advance();
    @(negedge wr_clk);
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL areset_first_gnt got=%b exp=0001", gnt); end
    n_vec++; if (owner !== 2'd0) begin n_err++; $display("FAIL areset_first_owner got=%0d exp=0", owner); end
  endtask

  task automatic test_random();
    int                 wait_arb [NUM_REQ];
    logic [NUM_REQ-1:0] prev_gnt;
    logic [NUM_REQ-1:0] prev_req;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      base[i]     = 8'($urandom_range(0, 255));
      wait_arb[i] = 0;
    end
    prev_gnt = '0;
    prev_req = '0;
    apply_inputs();
    for (int c = 0; c < 10000; c++) begin
      @(negedge wr_clk);
      n_vec++;
      if ({gnt, fifo_wr_en, fifo_wdata, owner, burst_cnt, busy} !==
          {exp_gnt, exp_wr, exp_data, OWN_W'(m_owner), BCNT_W'(m_cnt), m_active}) begin
        n_err++;
        $display("FAIL rand_outputs cyc=%0d got gnt=%b wr=%b d=%h own=%0d cnt=%0d busy=%b exp gnt=%b wr=%b d=%h own=%0d cnt=%0d busy=%b",
                 c, gnt, fifo_wr_en, fifo_wdata, owner, burst_cnt, busy,
                 exp_gnt, exp_wr, exp_data, m_owner, m_cnt, m_active);
      end
      n_vec++; if (fifo_wr_en === 1'b1 && fifo_full === 1'b1) begin n_err++; $display("FAIL rand_write_while_full cyc=%0d got=1 exp=0", c); end
      n_vec++; if ($countones(gnt) > 1) begin n_err++; $display("FAIL rand_gnt_onehot cyc=%0d got=%b exp=onehot0", c, gnt); end
      if (gnt != '0 && prev_gnt == '0) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gnt[i]) wait_arb[i] = 0;
          else if (prev_req[i]) begin
            wait_arb[i]++;
            n_vec++;
            if (wait_arb[i] > NUM_REQ - 1) begin
              n_err++;
              $display("FAIL rand_fairness req=%0d got=%0d_losses exp<=%0d", i, wait_arb[i], NUM_REQ - 1);
            end
          end
        end
      end
      prev_gnt = gnt;
      prev_req = req;
      advance();
      for (int i = 0; i < NUM_REQ; i++)
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 6);
      fifo_full = ($urandom_range(0, 3) == 0);
      apply_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
